uart_cmd_master: RTL and testbench

UART_CMD_MASTER -- requirements
Module: uart_cmd_master

---
 rtl/uart_cmd_pkg.sv | 26 ++
 rtl/uart_cmd_master_byte_tx.sv | 62 ++++++
 rtl/uart_cmd_master.sv | 210 +++++++++++++++++++++
 tb/tb_uart_cmd_master.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - shared opcodes, state encodings and frame constants for the UART command master
package uart_cmd_pkg;

  localparam logic [7:0] CmdWrite = 8'h77;
  localparam logic [7:0] CmdRead  = 8'h72;

  localparam int DataBits  = 8;
  localparam int FrameBits = 10;  // start + 8 data + stop

  typedef enum logic [2:0] {
    IDLE,
    SEND_CMD,
    SEND_ADDR,
    SEND_DATA,
    WAIT_RSP,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_phase_e;

endpackage

// File: rtl/uart_cmd_master_byte_tx.sv
// rtl/uart_cmd_master_byte_tx.sv - 8N1 byte serializer; a start on the last stop-bit cycle chains the next byte
module uart_byte_tx
  import uart_cmd_pkg::*;
#(
  parameter int BitCycles = 1154
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       tx_o
);

  localparam int CntW = (BitCycles > 1) ? $clog2(BitCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(BitCycles - 1);
  localparam logic [3:0]      BitLast = 4'(FrameBits - 1);

  logic            active_q;
  logic            tx_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      bit_q;
  logic [8:0]      shift_q;
  logic            last_cycle;

  assign last_cycle = active_q && (bit_q == BitLast) && (cnt_q == CntLast);
  assign busy_o     = active_q;
  assign done_o     = last_cycle;
  assign tx_o       = tx_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      tx_q     <= 1'b1;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
    end else if (start_i && (!active_q || last_cycle)) begin
      active_q <= 1'b1;
      tx_q     <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= {1'b1, byte_i};
    end else if (active_q) begin
      if (cnt_q == CntLast) begin
        cnt_q <= '0;
        if (bit_q == BitLast) begin
          active_q <= 1'b0;
          tx_q     <= 1'b1;
        end else begin
          bit_q   <= bit_q + 4'd1;
          tx_q    <= shift_q[0];
          shift_q <= {1'b1, shift_q[8:1]};
        end
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_cmd_master.sv
// rtl/uart_cmd_master.sv - issues write/read command frames over UART and collects the one-byte read reply
module uart_cmd_master
  import uart_cmd_pkg::*;
#(
  parameter int ClockFreq     = 133_000_000,
  parameter int BaudRate      = 115200,
  parameter int TimeoutCycles = 2_000_000
) (
  input  logic       i_sys_clk,
  input  logic       i_rst_n,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_req_write,
  input  logic [7:0] i_req_addr,
  input  logic [7:0] i_req_data,
  output logic       o_done,
  output logic [7:0] o_rsp_data,
  output logic       o_rsp_error,
  output logic       o_busy,
  output logic       o_tx,
  input  logic       i_rx
);

  localparam int UartBitCycles = ClockFreq / BaudRate;
  localparam int HalfBitCycles = UartBitCycles / 2;
  localparam int BitW = (UartBitCycles > 1) ? $clog2(UartBitCycles) : 1;
  localparam int ToW  = $clog2(TimeoutCycles + 1);
  localparam logic [BitW-1:0] BitLast  = BitW'(UartBitCycles - 1);
  localparam logic [BitW-1:0] HalfLast = BitW'(HalfBitCycles - 1);
  localparam logic [ToW-1:0]  ToLast   = ToW'(TimeoutCycles - 1);

  state_e          state_q;
  rx_phase_e       rx_phase_q;
  logic            write_q;
  logic [7:0]      addr_q;
  logic [7:0]      data_q;
  logic            done_q;
  logic [7:0]      rsp_data_q;
  logic            rsp_error_q;
  logic            rx_s1_q;
  logic            rx_s2_q;
  logic            rx_prev_q;
  logic [BitW-1:0] rx_cnt_q;
  logic [2:0]      rx_bits_q;
  logic [7:0]      rx_shift_q;
  logic [ToW-1:0]  to_cnt_q;

  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_busy;
  logic       tx_done;
  logic       accept;
  logic       rx_fall;
  logic       start_pending;

  assign o_req_ready   = (state_q == IDLE) && !tx_busy;
  assign accept        = i_req_valid && o_req_ready;
  assign o_busy        = (state_q != IDLE);
  assign o_done        = done_q;
  assign o_rsp_data    = rsp_data_q;
  assign o_rsp_error   = rsp_error_q;
  assign rx_fall       = rx_prev_q && !rx_s2_q;
  assign start_pending = (rx_phase_q == RX_IDLE) || (rx_phase_q == RX_START);

  // Next byte is offered on the serializer's last stop-bit cycle so frames chain with no gap.
  always_comb begin
    tx_start = 1'b0;
    tx_byte  = 8'h00;
    case (state_q)
      IDLE: begin
        tx_start = accept;
        tx_byte  = i_req_write ? CmdWrite : CmdRead;
      end
      SEND_CMD: begin
        tx_start = tx_done;
        tx_byte  = addr_q;
      end
      SEND_ADDR: begin
        tx_start = tx_done && write_q;
        tx_byte  = data_q;
      end
      default: ;
    endcase
  end

  uart_byte_tx #(
    .BitCycles(UartBitCycles)
  ) u_byte_tx (
    .clk_i  (i_sys_clk),
    .rst_ni (i_rst_n),
    .start_i(tx_start),
    .byte_i (tx_byte),
    .busy_o (tx_busy),
    .done_o (tx_done),
    .tx_o   (o_tx)
  );

  always_ff @(posedge i_sys_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      rx_phase_q  <= RX_IDLE;
      write_q     <= 1'b0;
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
      done_q      <= 1'b0;
      rsp_data_q  <= 8'h00;
      rsp_error_q <= 1'b0;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      rx_cnt_q    <= '0;
      rx_bits_q   <= '0;
      rx_shift_q  <= 8'h00;
      to_cnt_q    <= '0;
    end else begin
      rx_s1_q   <= i_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            write_q <= i_req_write;
            addr_q  <= i_req_addr;
            data_q  <= i_req_data;
            state_q <= SEND_CMD;
          end
        end
        SEND_CMD: begin
          if (tx_done) state_q <= SEND_ADDR;
        end
        SEND_ADDR: begin
          if (tx_done) begin
            if (write_q) begin
              state_q <= SEND_DATA;
            end else begin
              state_q    <= WAIT_RSP;
              rx_phase_q <= RX_IDLE;
              rx_cnt_q   <= '0;
              to_cnt_q   <= '0;
            end
          end
        end
        SEND_DATA: begin
          if (tx_done) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            rsp_data_q  <= 8'h00;
            rsp_error_q <= 1'b0;
          end
        end
        WAIT_RSP: begin
          to_cnt_q <= to_cnt_q + ToW'(1);
          // The timeout only applies until a start bit has been confirmed at mid-bit.
          if (start_pending && (to_cnt_q == ToLast)) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            rsp_data_q  <= 8'h00;
            rsp_error_q <= 1'b1;
            rx_phase_q  <= RX_IDLE;
          end else begin
            case (rx_phase_q)
              RX_IDLE: begin
                if (rx_fall) begin
                  rx_phase_q <= RX_START;
                  rx_cnt_q   <= '0;
                end
              end
              RX_START: begin
                if (rx_cnt_q == HalfLast) begin
                  rx_cnt_q   <= '0;
                  rx_bits_q  <= '0;
                  rx_phase_q <= rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                  rx_cnt_q <= rx_cnt_q + BitW'(1);
                end
              end
              RX_DATA: begin
                if (rx_cnt_q == BitLast) begin
                  rx_cnt_q   <= '0;
                  rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                  rx_bits_q  <= rx_bits_q + 3'd1;
                  if (rx_bits_q == 3'(DataBits - 1)) rx_phase_q <= RX_STOP;
                end else begin
                  rx_cnt_q <= rx_cnt_q + BitW'(1);
                end
              end
              default: begin
                if (rx_cnt_q == BitLast) begin
                  state_q     <= DONE;
                  done_q      <= 1'b1;
                  rsp_data_q  <= rx_shift_q;
                  rsp_error_q <= !rx_s2_q;
                  rx_phase_q  <= RX_IDLE;
                  rx_cnt_q    <= '0;
                end else begin
                  rx_cnt_q <= rx_cnt_q + BitW'(1);
                end
              end
            endcase
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_master.sv
// tb/tb_uart_cmd_master.sv - self-checking bench: directed vector table, reset abort sequence, random transactions
module tb_uart_cmd_master;

  localparam int ClockFreq = 25_344_000;
  localparam int BaudRate  = 115200;
  localparam int Bit       = ClockFreq / BaudRate;  // 220 cycles per bit
  localparam int Timeout   = 3000;

  typedef struct {
    bit         wr;
    logic [7:0] addr;
    logic [7:0] data;
    int         rx_mode;  // 0 silent line, 1 reply, 2 short glitch then reply
    logic [7:0] reply;
    bit         stop_bit;
    int         delay;    // reply start, in cycles after the last transmitted stop bit
    logic [7:0] exp_data;
    bit         exp_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_data = 8'h00;
  logic       rx = 1'b1;
  logic       req_ready;
  logic       done;
  logic [7:0] rsp_data;
  logic       rsp_error;
  logic       busy;
  logic       tx;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  uart_cmd_master #(
    .ClockFreq    (ClockFreq),
    .BaudRate     (BaudRate),
    .TimeoutCycles(Timeout)
  ) dut (
    .i_sys_clk  (clk),
    .i_rst_n    (rst_n),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_req_write(req_write),
    .i_req_addr (req_addr),
    .i_req_data (req_data),
    .o_done     (done),
    .o_rsp_data (rsp_data),
    .o_rsp_error(rsp_error),
    .o_busy     (busy),
    .o_tx       (tx),
    .i_rx       (rx)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference response: what the reply line carries decides the outcome.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (v.wr) begin
      r.exp_data = 8'h00;
      r.exp_err  = 1'b0;
    end else if (v.rx_mode == 0) begin
      r.exp_data = 8'h00;
      r.exp_err  = 1'b1;
    end else begin
      r.exp_data = v.reply;
      r.exp_err  = !v.stop_bit;
    end
    return r;
  endfunction

  function automatic logic rx_level(input vec_t v, input int w);
    int bp;
    if (v.rx_mode == 2 && w >= 300 && w < 400) return 1'b0;
    if (v.rx_mode == 0 || w < v.delay || w >= v.delay + 10 * Bit) return 1'b1;
    bp = (w - v.delay) / Bit;
    if (bp == 0) return 1'b0;
    if (bp == 9) return v.stop_bit;
    return v.reply[bp-1];
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    logic [7:0] bytes[3];
    int bad[3];
    int other_bad;
    int nbytes;
    int nc;
    int done_at;
    int lo;
    int hi;
    nbytes   = v.wr ? 3 : 2;
    nc       = nbytes * 10 * Bit;
    bytes[0] = v.wr ? 8'h77 : 8'h72;
    bytes[1] = v.addr;
    bytes[2] = v.data;
    bad      = '{0, 0, 0};
    other_bad = 0;
    req_valid = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_data  = v.data;
    check({tag, "_ready_idle"}, req_ready, 1);
    step();
    req_valid = 1'b0;
    req_write = ~v.wr;
    req_addr  = 8'($urandom);
    req_data  = 8'($urandom);
    for (int c = 1; c <= nc; c++) begin
      int   j;
      int   k;
      int   pos;
      logic e;
      j   = (c - 1) / Bit;
      k   = j / 10;
      pos = j % 10;
      if (pos == 0) e = 1'b0;
      else if (pos == 9) e = 1'b1;
      else e = bytes[k][pos-1];
      if (tx !== e) bad[k]++;
      if (done !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b1) other_bad++;
      req_valid = (c >= 5 && c < 10);
      step();
    end
    for (int k = 0; k < nbytes; k++) check($sformatf("%s_tx_byte%0d_bad_cycles", tag, k), bad[k], 0);
    check({tag, "_status_during_tx"}, other_bad, 0);
    done_at = -1;
    for (int w = 0; w < Timeout + 12 * Bit; w++) begin
      rx = rx_level(v, w);
      if (done === 1'b1) begin
        done_at = nc + 1 + w;
        break;
      end
      step();
    end
    rx = 1'b1;
    check({tag, "_done_seen"}, (done_at >= 0), 1);
    if (v.wr) begin
      check({tag, "_write_latency"}, done_at, 30 * Bit + 1);
    end else if (v.rx_mode == 0) begin
      check({tag, "_timeout_latency"}, done_at, 20 * Bit + Timeout + 1);
    end else begin
      lo = 20 * Bit + 1 + v.delay + 9 * Bit + Bit / 2;
      hi = 20 * Bit + 1 + v.delay + 10 * Bit;
      check({tag, "_reply_latency_window"}, (done_at >= lo && done_at <= hi), 1);
    end
    check({tag, "_rsp_data"}, rsp_data, v.exp_data);
    check({tag, "_rsp_error"}, rsp_error, v.exp_err);
    step();
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_ready_after_done"}, req_ready, 1);
    check({tag, "_rsp_data_hold"}, rsp_data, v.exp_data);
    check({tag, "_rsp_error_hold"}, rsp_error, v.exp_err);
  endtask

  initial begin
    vec_t vecs[5];
    vec_t v;
    int tx_bad;
    int done_bad;

    vecs[0] = '{1'b1, 8'h05, 8'h8F, 0, 8'h00, 1'b1, 0,    8'h00, 1'b0};
    vecs[1] = '{1'b0, 8'h05, 8'h00, 1, 8'h8F, 1'b1, 2000, 8'h8F, 1'b0};
    vecs[2] = '{1'b0, 8'h07, 8'h00, 0, 8'h00, 1'b1, 0,    8'h00, 1'b1};
    vecs[3] = '{1'b0, 8'h2A, 8'h00, 2, 8'h9A, 1'b1, 1000, 8'h9A, 1'b0};
    vecs[4] = '{1'b0, 8'h11, 8'h00, 1, 8'h3C, 1'b0, 500,  8'h3C, 1'b1};

    repeat (3) step();
    check("reset_tx", tx, 1);
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);
    check("reset_rsp_data", rsp_data, 8'h00);
    check("reset_rsp_error", rsp_error, 0);
    rst_n = 1'b1;
    step();
    check("ready_after_release", req_ready, 1);

    for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Abort a read while its address byte is on the wire.
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'h21;
    step();
    req_valid = 1'b0;
    repeat (15 * Bit) step();
    check("abort_busy_before_reset", busy, 1);
    rst_n = 1'b0;
    step();
    tx_bad   = 0;
    done_bad = 0;
    check("abort_rsp_data_cleared", rsp_data, 8'h00);
    check("abort_rsp_error_cleared", rsp_error, 0);
    for (int i = 0; i < 4; i++) begin
      if (tx !== 1'b1) tx_bad++;
      if (done !== 1'b0) done_bad++;
      step();
    end
    rst_n = 1'b1;
    step();
    check("abort_ready_after_release", req_ready, 1);
    for (int i = 0; i < 3 * Bit; i++) begin
      if (tx !== 1'b1) tx_bad++;
      if (done !== 1'b0 || busy !== 1'b0) done_bad++;
      step();
    end
    check("abort_tx_idle_cycles", tx_bad, 0);
    check("abort_no_done_cycles", done_bad, 0);
    v = '{1'b1, 8'h0F, 8'h9A, 0, 8'h00, 1'b1, 0, 8'h00, 1'b0};
    run_txn(model(v), "after_abort");

    for (int n = 0; n < 3; n++) begin
      v.wr       = 1'($urandom_range(0, 1));
      v.addr     = 8'($urandom);
      v.data     = 8'($urandom);
      v.rx_mode  = v.wr ? 0 : int'($urandom_range(0, 2));
      v.reply    = 8'($urandom);
      v.stop_bit = 1'($urandom_range(0, 1));
      v.delay    = (v.rx_mode == 2) ? 500 + int'($urandom_range(0, 1000)) : int'($urandom_range(0, 1500));
      run_txn(model(v), $sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
